// File: rtl/csi2_pkg.sv
// Shared CSI-2 low-level protocol definitions: data types, header ECC,
// payload CRC-16 and the packet builder state encoding.
package csi2_pkg;

    localparam logic [5:0]  DT_FS           = 6'h00;
    localparam logic [5:0]  DT_FE           = 6'h01;
    localparam logic [5:0]  DT_RAW8         = 6'h2A;
    localparam logic [5:0]  DT_RAW10        = 6'h2B;
    localparam logic [5:0]  LONG_DT_MIN_DEF = 6'h10;

    localparam logic [15:0] CRC_POLY        = 16'h8408;
    localparam logic [15:0] CRC_INIT_DEF    = 16'hFFFF;

    typedef struct packed {
        logic [7:0]  di;
        logic [15:0] wc;
    } hdr_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_H_DI,
        ST_H_WCL,
        ST_H_WCH,
        ST_H_ECC,
        ST_PAY,
        ST_F_CRCL,
        ST_F_CRCH
    } state_e;

    // Hamming parity over D[23:0] = {WC, DI}; top two ECC bits are always zero
    function automatic logic [7:0] csi2_ecc(input logic [23:0] d);
        logic [7:0] e;
        e    = '0;
        e[0] = d[0]  ^ d[1]  ^ d[2]  ^ d[4]  ^ d[5]  ^ d[7]  ^ d[10] ^ d[11] ^ d[13] ^ d[16] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
        e[1] = d[0]  ^ d[1]  ^ d[3]  ^ d[4]  ^ d[6]  ^ d[8]  ^ d[10] ^ d[12] ^ d[14] ^ d[17] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
        e[2] = d[0]  ^ d[2]  ^ d[3]  ^ d[5]  ^ d[6]  ^ d[9]  ^ d[11] ^ d[12] ^ d[15] ^ d[18] ^ d[20] ^ d[21] ^ d[22];
        e[3] = d[1]  ^ d[2]  ^ d[3]  ^ d[7]  ^ d[8]  ^ d[9]  ^ d[13] ^ d[14] ^ d[15] ^ d[19] ^ d[20] ^ d[21] ^ d[23];
        e[4] = d[4]  ^ d[5]  ^ d[6]  ^ d[7]  ^ d[8]  ^ d[9]  ^ d[16] ^ d[17] ^ d[18] ^ d[19] ^ d[20] ^ d[22] ^ d[23];
        e[5] = d[10] ^ d[11] ^ d[12] ^ d[13] ^ d[14] ^ d[15] ^ d[16] ^ d[17] ^ d[18] ^ d[19] ^ d[21] ^ d[22] ^ d[23];
        return e;
    endfunction

    // Reflected CRC-16 step, byte consumed LSB first
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            c = (c[0] ^ data[i]) ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/csi2_crc16.sv
// Byte-wise CRC-16 register; init has priority over en. Shared with the receive path.
module csi2_crc16
    import csi2_pkg::*;
#(
    parameter logic [15:0] INIT = CRC_INIT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [15:0] crc
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (init) begin
            crc_d = INIT;
        end else if (en) begin
            crc_d = crc16_byte(crc_q, data);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_q <= INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/csi2_packet_builder.sv
// CSI-2 transmit packet builder: serializes header, pass-through payload and
// CRC footer into a single byte stream with SOP/EOP framing.
module csi2_packet_builder
    import csi2_pkg::*;
#(
    parameter logic [15:0] CRC_INIT    = CRC_INIT_DEF,
    parameter logic [5:0]  LONG_DT_MIN = LONG_DT_MIN_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_di,
    input  logic [15:0] cmd_wc,
    input  logic        pay_valid,
    output logic        pay_ready,
    input  logic [7:0]  pay_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_sop,
    output logic        out_eop,
    output logic        busy
);

    state_e      state_q;
    hdr_t        hdr_q;
    logic [7:0]  ecc_q;
    logic        long_q;
    logic [15:0] cnt_q;
    logic        cmd_ready_q;
    logic [15:0] crc;

    logic cmd_acc;
    logic pay_xfer;

    assign cmd_acc  = cmd_valid && cmd_ready_q;
    assign pay_xfer = (state_q == ST_PAY) && pay_valid && out_ready;

    csi2_crc16 #(.INIT(CRC_INIT)) u_crc (
        .clk  (clk),
        .rst  (reset),
        .init (cmd_acc),
        .en   (pay_xfer),
        .data (pay_data),
        .crc  (crc)
    );

    // cmd_ready is a flop so it stays low through reset and rises one edge later
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            hdr_q       <= '0;
            ecc_q       <= '0;
            long_q      <= 1'b0;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cmd_ready_q <= ~cmd_acc;
                    if (cmd_acc) begin
                        hdr_q   <= '{di: cmd_di, wc: cmd_wc};
                        ecc_q   <= csi2_ecc({cmd_wc, cmd_di});
                        long_q  <= (cmd_di[5:0] >= LONG_DT_MIN);
                        cnt_q   <= cmd_wc;
                        state_q <= ST_H_DI;
                    end
                end
                ST_H_DI:  if (out_ready) state_q <= ST_H_WCL;
                ST_H_WCL: if (out_ready) state_q <= ST_H_WCH;
                ST_H_WCH: if (out_ready) state_q <= ST_H_ECC;
                ST_H_ECC: begin
                    if (out_ready) begin
                        if (!long_q) begin
                            state_q     <= ST_IDLE;
                            cmd_ready_q <= 1'b1;
                        end else if (cnt_q == 16'd0) begin
                            state_q <= ST_F_CRCL;
                        end else begin
                            state_q <= ST_PAY;
                        end
                    end
                end
                ST_PAY: begin
                    if (pay_xfer) begin
                        cnt_q <= cnt_q - 16'd1;
                        if (cnt_q == 16'd1) state_q <= ST_F_CRCL;
                    end
                end
                ST_F_CRCL: if (out_ready) state_q <= ST_F_CRCH;
                ST_F_CRCH: begin
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        cmd_ready_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Byte mux; everything is forced to zero whenever no byte is presented
    always_comb begin
        out_valid = 1'b0;
        out_data  = 8'h00;
        out_sop   = 1'b0;
        out_eop   = 1'b0;
        pay_ready = 1'b0;
        case (state_q)
            ST_H_DI: begin
                out_valid = 1'b1;
                out_data  = hdr_q.di;
                out_sop   = 1'b1;
            end
            ST_H_WCL: begin
                out_valid = 1'b1;
                out_data  = hdr_q.wc[7:0];
            end
            ST_H_WCH: begin
                out_valid = 1'b1;
                out_data  = hdr_q.wc[15:8];
            end
            ST_H_ECC: begin
                out_valid = 1'b1;
                out_data  = ecc_q;
                out_eop   = ~long_q;
            end
            ST_PAY: begin
                pay_ready = out_ready;
                out_valid = pay_valid;
                out_data  = pay_valid ? pay_data : 8'h00;
            end
            ST_F_CRCL: begin
                out_valid = 1'b1;
                out_data  = crc[7:0];
            end
            ST_F_CRCH: begin
                out_valid = 1'b1;
                out_data  = crc[15:8];
                out_eop   = 1'b1;
            end
            default: ;
        endcase
    end

    assign cmd_ready = cmd_ready_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: doc/csi2_packet_builder.md
# csi2_packet_builder

Transmit-side CSI-2 low-level packet builder: accepts a packet command (data ID, word count) and, for long packets, a payload byte stream, and emits the serialized byte stream. Short packets are a 4-byte header; long packets are a header, WC payload bytes, then a 2-byte CRC footer. It sits between the pixel/payload source and the lane distributor, and produces exactly the format the receive-side packet stripper parses.

## Interface
- `CRC_INIT`, default 16'hFFFF: CRC-16 seed loaded at every long-packet start.
- `LONG_DT_MIN`, default 6'h10: data types (DI[5:0]) at or above this value are long packets; below are short.
- `clk` in 1: single clock, all logic on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `cmd_valid` in 1: packet command present.
- `cmd_ready` out 1: builder idle; command accepted when `cmd_valid && cmd_ready`.
- `cmd_di` in 8: data ID; [7:6] virtual channel, [5:0] data type.
- `cmd_wc` in 16: word count (long) or short-packet data field (short).
- `pay_valid` in 1: payload byte present.
- `pay_ready` out 1: payload byte consumed this cycle.
- `pay_data` in 8: payload byte.
- `out_valid` out 1: output byte present.
- `out_ready` in 1: downstream accepts byte.
- `out_data` out 8: serialized byte.
- `out_sop` out 1: qualifies first header byte.
- `out_eop` out 1: qualifies last byte of packet (ECC byte for short packets, CRC high byte for long).
- `busy` out 1: high in any state other than IDLE.

## Operation
- States: IDLE, H_DI, H_WCL, H_WCH, H_ECC, PAY, F_CRCL, F_CRCH.
- IDLE: `cmd_ready`=1; on accept, latch DI, WC, compute ECC, classify long/short, load CRC with `CRC_INIT`, load down-counter with WC → H_DI.
- Header states each present one byte with `out_valid`=1: DI, WC[7:0], WC[15:8], ECC. Advance only on `out_ready`.
- H_ECC exit: short → IDLE; long with WC≠0 → PAY; long with WC=0 → F_CRCL (footer = 16'hFFFF).
- PAY: pass-through; `out_valid`=`pay_valid`, `out_data`=`pay_data`, `pay_ready`=`out_ready`. On each transfer: CRC updated with the byte, counter decremented; transfer with counter=1 → F_CRCL. `pay_ready`=0 in all other states.
- F_CRCL emits CRC[7:0], F_CRCH emits CRC[15:8] with `out_eop` → IDLE.
- ECC: 6-bit CSI-2 Hamming code P0–P5 over header bits D[23:0] = {WC, DI}, D0 = DI[0]; ECC[7:6]=0.
- CRC: CRC-16, reflected polynomial 16'h8408, payload bytes LSB first, no final XOR; footer transmitted low byte first.
- `out_data`, `out_sop`, `out_eop` are don't-care-free: driven 0 whenever `out_valid`=0.
- No reaction to extra payload bytes outside PAY; source must supply exactly WC bytes.

## Timing
- Reset values: `cmd_ready`=0 during reset, 1 in the first cycle after release; `out_valid`, `out_sop`, `out_eop`, `pay_ready`, `busy`=0; `out_data`=8'h00; CRC=`CRC_INIT`; state IDLE.
- First header byte valid the cycle after command acceptance; no new command accepted in the cycle a packet ends (IDLE reached next edge), so minimum gap is one cycle.
- Without backpressure: short packet 4 cycles, long packet WC+6 cycles of `out_valid`.
- `out_valid` with `out_ready`=0 holds data and flags stable until transfer (header/footer states); in PAY stability is the source's responsibility.
- PAY with `pay_valid`=0: `out_valid`=0, no state change.
- Reset mid-packet: immediate return to IDLE, partial packet abandoned, no EOP emitted.
- WC=16'hFFFF: counter 16-bit, no wrap; exactly 65535 payload bytes.

## Structure
- Shared package `csi2_pkg`: data-type constants (FS 6'h00, FE 6'h01, RAW8 6'h2A, RAW10 6'h2B), `LONG_DT_MIN` default, ECC function, CRC polynomial and byte-update function, state enum.
- One sub-module: `csi2_crc16` (byte-wise CRC register with `init`, `en`, `data` inputs, `crc` output), reusable by the receive path.

## Test plan
- Short packet DI=8'h00, WC=16'h0000 → bytes 00 00 00 00, SOP on first, EOP on fourth, `cmd_ready` high again after.
- Short packet DI=8'h00, WC=16'h0001 → bytes 00 01 00 1A.
- Long packet DI=8'h2B, WC=4 with payload 01 02 03 04 → header 2B 04 00 34, payload passed through, footer equals reference-model CRC, low byte first, EOP on last.
- Long packet DI=8'h2A, WC=24, payload FF 00 00 02 B9 DC F3 72 BB D4 B8 5A C8 75 C2 7C 81 F8 05 DF FF 00 00 01 → footer F0 00.
- Long WC=0 → header then FF FF; random `out_ready`/`pay_valid` stalls on WC=24 packet → identical byte sequence, no drops or duplicates.
- Reset asserted during PAY → outputs zero same cycle, next command produces correct packet with CRC from `CRC_INIT`.
